data_ram_responder: RTL

DATA_RAM_RESPONDER -- requirements
Module: data_ram_responder

---
 rtl/data_ram_responder_if.sv | 22 ++
 rtl/data_ram_responder.sv | 113 +++++++++++
 2 files changed

// File: rtl/data_ram_responder_if.sv
// Request/response bundle between a requester and data_ram_responder.
// A nonzero read or write address is itself the request.
interface data_ram_responder_if;
  logic [31:0] readAddr_i;
  logic [31:0] writeAddr_i;
  logic [63:0] writeData_i;
  logic [3:0]  writeMask_i;
  logic [63:0] readData_o;
  logic        dataOk_o;
  logic [2:0]  writeState_o;
  logic        busy_o;

  modport master (
    output readAddr_i, writeAddr_i, writeData_i, writeMask_i,
    input  readData_o, dataOk_o, writeState_o, busy_o
  );

  modport slave (
    input  readAddr_i, writeAddr_i, writeData_i, writeMask_i,
    output readData_o, dataOk_o, writeState_o, busy_o
  );
endinterface

// File: rtl/data_ram_responder.sv
// 64-bit word RAM serving one read (fixed latency) or one lane-masked write
// (fixed 3 cycles) at a time; reads win when both requests are present.
module data_ram_responder #(
  parameter int DEPTH        = 512,
  parameter int READ_LATENCY = 2
) (
  input logic            clk,
  input logic            reset,
  data_ram_responder_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] LAT_LAST = 3'((READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0);

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    READ_DONE,
    WRITE_ACCEPT,
    WRITE_MERGE,
    WRITE_DONE
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [2:0]  r_latCnt;
  logic [31:0] r_addr;
  logic [63:0] r_data;
  logic [3:0]  r_mask;
  logic [63:0] r_readData;
  logic [63:0] r_mem [DEPTH];

  logic [31:0]   w_rdAddr;
  logic [AW-1:0] w_rdIdx;
  logic [AW-1:0] w_wrIdx;
  logic          w_rdInRange;
  logic          w_wrInRange;
  logic          w_unusedLowBits;

  // With latency 1 the read word is fetched on the acceptance edge itself,
  // so the address must come straight from the bus rather than the latch.
  assign w_rdAddr        = (r_state == IDLE) ? bus.readAddr_i : r_addr;
  assign w_rdIdx         = w_rdAddr[AW+2:3];
  assign w_wrIdx         = r_addr[AW+2:3];
  assign w_rdInRange     = (w_rdAddr[31:AW+3] == '0);
  assign w_wrInRange     = (r_addr[31:AW+3] == '0);
  assign w_unusedLowBits = ^{w_rdAddr[2:0], r_addr[2:0]};

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (bus.readAddr_i != '0)
          w_nextState = (READ_LATENCY == 1) ? READ_DONE : READ_WAIT;
        else if (bus.writeAddr_i != '0)
          w_nextState = WRITE_ACCEPT;
      end
      READ_WAIT:    if (r_latCnt == LAT_LAST) w_nextState = READ_DONE;
      READ_DONE:    w_nextState = IDLE;
      WRITE_ACCEPT: w_nextState = WRITE_MERGE;
      WRITE_MERGE:  w_nextState = WRITE_DONE;
      WRITE_DONE:   w_nextState = IDLE;
      default:      w_nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.dataOk_o     = (r_state == READ_DONE);
    bus.busy_o       = (r_state != IDLE);
    bus.writeState_o = 3'b000;
    case (r_state)
      WRITE_ACCEPT: bus.writeState_o = 3'b001;
      WRITE_MERGE:  bus.writeState_o = 3'b011;
      WRITE_DONE:   bus.writeState_o = 3'b111;
      default:      bus.writeState_o = 3'b000;
    endcase
  end

  assign bus.readData_o = r_readData;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_latCnt   <= 3'd0;
      r_addr     <= '0;
      r_data     <= '0;
      r_mask     <= '0;
      r_readData <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == READ_WAIT) r_latCnt <= r_latCnt + 3'd1;
      else                      r_latCnt <= 3'd0;
      // Only the snapshot taken on the edge that leaves IDLE is ever used.
      if (r_state == IDLE) begin
        r_addr <= (bus.readAddr_i != '0) ? bus.readAddr_i : bus.writeAddr_i;
        r_data <= bus.writeData_i;
        r_mask <= bus.writeMask_i;
      end
      if (w_nextState == READ_DONE)
        r_readData <= w_rdInRange ? r_mem[w_rdIdx] : 64'h0;
    end
  end

  // Storage is deliberately not reset; reset forces IDLE so no commit occurs.
  always_ff @(posedge clk) begin
    if (r_state == WRITE_MERGE && w_wrInRange) begin
      for (int k = 0; k < 4; k++) begin
        if (r_mask[k]) r_mem[w_wrIdx][16*k +: 16] <= r_data[16*k +: 16];
      end
    end
  end

endmodule
